// File: rtl/sqrt_stream_ctrl.sv
// rtl/sqrt_stream_ctrl.sv - stochastic square-root job sequencer with embedded JK sqrt cell
// One operand in, one ones-count out; both LFSRs restart from their seeds on every job.
module sqrt_stream_ctrl #(
    parameter int               WIDTH  = 8,
    parameter int               WARM   = 4,
    parameter logic [WIDTH-1:0] SEED_D = WIDTH'('h5A),
    parameter logic [WIDTH-1:0] SEED_S = WIDTH'('hC3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = (WIDTH > 8) ? WIDTH : 8;

    // Primitive-polynomial feedback masks, bit t-1 set for tap t.
    function automatic logic [15:0] tap_table(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    localparam logic [15:0]      TAPS16    = tap_table(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS16[WIDTH-1:0];
    localparam logic [CW-1:0]    RUN_LAST  = CW'((1 << WIDTH) - 2);
    localparam logic [CW-1:0]    WARM_LAST = CW'(WARM - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] lfsr_s;
    logic [WIDTH-1:0] ones_cnt;
    logic [CW-1:0]    cnt;
    logic             jk;

    logic             s_in;
    logic             sel;
    logic             o;
    logic             jk_next;
    logic [WIDTH-1:0] lfsr_d_next;
    logic [WIDTH-1:0] lfsr_s_next;

    always_comb begin
        s_in        = (x_reg >= lfsr_d);
        sel         = lfsr_s[0];
        o           = sel ? s_in : jk;
        jk_next     = o ? ~jk : 1'b1;
        lfsr_d_next = {lfsr_d[WIDTH-2:0], ^(lfsr_d & TAPS)};
        lfsr_s_next = {lfsr_s[WIDTH-2:0], ^(lfsr_s & TAPS)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            x_reg     <= '0;
            jk        <= 1'b0;
            ones_cnt  <= '0;
            cnt       <= '0;
            lfsr_d    <= SEED_D;
            lfsr_s    <= SEED_S;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= in_data;
                        jk       <= 1'b0;
                        ones_cnt <= '0;
                        cnt      <= '0;
                        lfsr_d   <= SEED_D;
                        lfsr_s   <= SEED_S;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (WARM == 0) ? RUN : WARMUP;
                    end
                end
                WARMUP: begin
                    jk     <= jk_next;
                    lfsr_d <= lfsr_d_next;
                    lfsr_s <= lfsr_s_next;
                    if (cnt == WARM_LAST) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    jk       <= jk_next;
                    lfsr_d   <= lfsr_d_next;
                    lfsr_s   <= lfsr_s_next;
                    ones_cnt <= ones_cnt + WIDTH'(o);
                    if (cnt == RUN_LAST) begin
                        // Final count includes this cycle's cell output.
                        out_data  <= ones_cnt + WIDTH'(o);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_stream_ctrl.sv
// tb/tb_sqrt_stream_ctrl.sv - self-checking bench for sqrt_stream_ctrl (WIDTH=8, WARM=4)
module tb_sqrt_stream_ctrl;

    localparam int WIDTH = 8;
    localparam int WARM  = 4;
    localparam int M     = 255;
    localparam int LAT   = WARM + M + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_stream_ctrl #(.WIDTH(WIDTH), .WARM(WARM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // x^8+x^6+x^5+x^4+1 shift-left Fibonacci step
    function automatic int lfsr_step(input int v);
        return ((v << 1) & M) | ($countones(v & 'hB8) & 1);
    endfunction

    function automatic int model(input int x);
        int d, s, jk, o, cnt;
        d = 'h5A; s = 'hC3; jk = 0; cnt = 0;
        for (int i = 0; i < WARM + M; i++) begin
            o = (s & 1) ? ((x >= d) ? 1 : 0) : jk;
            if (i >= WARM) cnt += o;
            jk = o ? 1 - jk : 1;
            d = lfsr_step(d);
            s = lfsr_step(s);
        end
        return cnt;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int x, input int hold, input bit inject, output int res);
        int lat;
        int ready_bad;
        int hold_bad;
        int held;
        @(negedge clk);
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk("busy_rise", busy, 1);
        lat = 1;
        ready_bad = 0;
        while (!out_valid && lat < 4 * LAT) begin
            if (in_ready) ready_bad++;
            if (inject && lat == WARM + 100) begin
                in_valid = 1'b1;
                in_data  = 8'(~x);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, LAT);
        chk("in_ready_low_while_busy", ready_bad, 0);
        res = out_data;
        held = out_data;
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_data != 8'(held) || in_ready || busy) hold_bad++;
        end
        if (hold > 0) chk("done_hold_stable", hold_bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_in_ready", in_ready, 1);
        chk("pop_out_valid", out_valid, 0);
    endtask

    typedef struct {
        int x;
        int hold;
        bit inject;
        int exp;
    } vec_t;

    vec_t vecs[6];
    int   res;
    int   res_prev;
    int   xr;

    initial begin
        vecs[0] = '{x: 64,  hold: 0,  inject: 1'b0, exp: 0};
        vecs[1] = '{x: 64,  hold: 0,  inject: 1'b0, exp: 0};
        vecs[2] = '{x: 64,  hold: 50, inject: 1'b0, exp: 0};
        vecs[3] = '{x: 64,  hold: 2,  inject: 1'b1, exp: 0};
        vecs[4] = '{x: 0,   hold: 3,  inject: 1'b0, exp: 0};
        vecs[5] = '{x: 255, hold: 1,  inject: 1'b0, exp: 0};
        foreach (vecs[i]) vecs[i].exp = model(vecs[i].x);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);

        res_prev = -1;
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].x, vecs[i].hold, vecs[i].inject, res);
            chk($sformatf("vec%0d_x%0d_result", i, vecs[i].x), res, vecs[i].exp);
            if (i == 1) chk("back_to_back_identical", res, res_prev);
            res_prev = res;
        end

        // Abort at RUN cycle 100, then a clean job must complete.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (WARM + 99) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        run_job(255, 0, 1'b0, res);
        chk("after_abort_x255", res, model(255));

        for (int x = 0; x <= 256; x += 16) begin
            xr = (x > 255) ? 255 : x;
            run_job(xr, 0, 1'b0, res);
            chk($sformatf("sweep_x%0d", xr), res, model(xr));
        end

        for (int i = 0; i < 6; i++) begin
            xr = $urandom_range(0, 255);
            run_job(xr, $urandom_range(0, 5), 1'($urandom_range(0, 1)), res);
            chk($sformatf("rand_x%0d", xr), res, model(xr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
